usb_ep_out_scheduler: RTL
=========================

Name: usb_ep_out_scheduler

Overview:
- Registered round-robin scheduler sharing the single USB OUT packet datapath between N_EP_OUT endpoint requesters.
- A grant is held for a whole packet: it is released on end-of-packet, when the requester drops its request, or on a watchdog timeout.
- Priority then rotates to the next endpoint.
- Sits between the endpoint request lines and the OUT-packet receive/steering logic, replacing purely combinational fixed-priority selection.

Parameters:
- N_EP_OUT, 4, number of OUT endpoint requesters (>=1).
- TIMEOUT_CYCLES, 1024, maximum cycles one grant may be held; 0 disables the watchdog.

Ports:
- i_clk  input  1  clock.
- i_rstn  input  1  asynchronous active-low reset.
- i_outEp_req  input  N_EP_OUT  per-endpoint request; level, held until served.
- i_pktEnd  input  1  single-cycle pulse from the OUT datapath at end of the current packet.
- o_outEp_grant  output  N_EP_OUT  one-hot or zero grant, registered.
- o_grantValid  output  1  high when any grant bit is set.
- o_grantIdx  output  max(1,$clog2(N_EP_OUT))  binary index of the granted endpoint; holds its last value when not valid.
- o_timeout  output  1  single-cycle pulse when the watchdog forces a release.

Behaviour:
- Clock and reset:
  - One clock. Reset is asynchronous and active-low.
  - All flops (grant, valid, idx, priority pointer, counter, timeout, state) assert on the falling edge of i_rstn.
  - Release is synchronous to i_clk.
- Reset values:
  - o_outEp_grant=0, o_grantValid=0, o_grantIdx=0, o_timeout=0.
  - Priority pointer ptr=0, counter=0, state=IDLE.
- IDLE state:
  - If any i_outEp_req bit is set, select the first set bit scanning ptr, ptr+1, … wrapping modulo N_EP_OUT.
  - Register the selection into grant, idx and valid; go to GRANTED.
  - Latency: request asserted in cycle t gives the grant visible in cycle t+1.
  - i_pktEnd is ignored in IDLE.
- GRANTED state: the counter increments each cycle from 0 and saturates. Release conditions are evaluated every cycle:
  - (a) i_pktEnd=1;
  - (b) i_outEp_req[idx]=0;
  - (c) TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1.
  - On any release:
    - grant and valid clear next cycle;
    - ptr <= (idx+1) mod N_EP_OUT;
    - counter <= 0;
    - go to GAP.
  - o_timeout pulses in the cycle after (c), only when neither (a) nor (b) holds that same cycle. End-of-packet takes precedence, so no timeout pulse is raised.
  - While none hold, the grant is stable; requests from other endpoints have no effect.
- GAP state:
  - Exactly one cycle with all grants 0 (datapath turnaround), then IDLE.
  - The minimum spacing between two consecutive grants is therefore 2 zero-grant cycles.
- Invariants:
  - o_outEp_grant is never multi-hot.
  - A grant bit is only set if that endpoint's request was set in the selecting cycle.
  - o_grantValid == |o_outEp_grant.
- N_EP_OUT=1: idx is always 0; the rotation is a no-op.
- Reset mid-grant: outputs clear immediately (asynchronously); ptr returns to 0.

Test Plan:
- Reset, then req=4'b0110 held -> grant=4'b0010 at cycle 1, idx=1. After pktEnd, grant 0 for 2 cycles, then grant=4'b0100, idx=2.
- All req=4'b1111 held, pktEnd every 5th granted cycle -> grant sequence 0,1,2,3,0 with idx rotating. Each grant lasts 5 cycles; there is never a multi-hot grant.
- TIMEOUT_CYCLES=8, req=4'b0001 held, no pktEnd -> grant held 8 cycles, o_timeout pulses once in cycle 9, grant drops, regrant to endpoint 0 after the GAP/IDLE cycles.
- Granted endpoint 2 drops req mid-packet while req[3]=1 -> grant clears next cycle, then endpoint 3 is granted; o_timeout stays 0.
- pktEnd and the timeout boundary in the same cycle (TIMEOUT_CYCLES=4, pktEnd on the 4th granted cycle) -> release, o_timeout stays 0.
- Drive i_rstn low asynchronously (mid-clock) while granted to endpoint 3 -> all outputs 0 before the next edge. After release, req=4'b1001 gives endpoint 0 first (ptr reset).

Source files
------------

// File: rtl/usb_ep_out_scheduler.sv
// Round-robin scheduler that shares the single USB OUT packet datapath between endpoints.
// A grant is held for a whole packet, then released, followed by one turnaround cycle.
module usb_ep_out_scheduler #(
    parameter int unsigned N_EP_OUT       = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                                           i_clk,
    input  logic                                           i_rstn,
    input  logic [N_EP_OUT-1:0]                            i_outEp_req,
    input  logic                                           i_pktEnd,
    output logic [N_EP_OUT-1:0]                            o_outEp_grant,
    output logic                                           o_grantValid,
    output logic [$clog2(N_EP_OUT > 1 ? N_EP_OUT : 2)-1:0] o_grantIdx,
    output logic                                           o_timeout
);

    localparam int unsigned IW = $clog2(N_EP_OUT > 1 ? N_EP_OUT : 2);
    localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(N_EP_OUT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StGranted,
        StGap
    } state_e;

    state_e              state_q;
    logic [IW-1:0]       ptr_q;
    logic [IW-1:0]       idx_q;
    logic [CW-1:0]       cnt_q;
    logic [N_EP_OUT-1:0] grant_q;
    logic                valid_q;
    logic                timeout_q;

    logic                found;
    logic [IW-1:0]       sel;
    logic [IW-1:0]       cand_idx;
    logic [N_EP_OUT-1:0] sel_oh;
    int unsigned         cand;

    // First requester at or after the priority pointer, wrapping around.
    always_comb begin
        found    = 1'b0;
        sel      = '0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned k = 0; k < N_EP_OUT; k++) begin
            cand     = (32'(ptr_q) + k) % N_EP_OUT;
            cand_idx = IW'(cand);
            if (!found && i_outEp_req[cand_idx]) begin
                found = 1'b1;
                sel   = cand_idx;
            end
        end
        sel_oh      = '0;
        sel_oh[sel] = 1'b1;
    end

    logic          req_held;
    logic          tmo_hit;
    logic          release_now;
    logic [IW-1:0] next_ptr;

    always_comb begin
        req_held    = i_outEp_req[idx_q];
        tmo_hit     = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);
        release_now = i_pktEnd || !req_held || tmo_hit;
        next_ptr    = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            grant_q   <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    timeout_q <= 1'b0;
                    if (found) begin
                        grant_q <= sel_oh;
                        idx_q   <= sel;
                        valid_q <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= StGranted;
                    end
                end
                StGranted: begin
                    if (release_now) begin
                        grant_q   <= '0;
                        valid_q   <= 1'b0;
                        ptr_q     <= next_ptr;
                        cnt_q     <= '0;
                        // End-of-packet or a dropped request wins over the watchdog.
                        timeout_q <= tmo_hit && !i_pktEnd && req_held;
                        state_q   <= StGap;
                    end else if (cnt_q != '1) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StGap: begin
                    timeout_q <= 1'b0;
                    state_q   <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign o_outEp_grant = grant_q;
    assign o_grantValid  = valid_q;
    assign o_grantIdx    = idx_q;
    assign o_timeout     = timeout_q;

endmodule
